// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel: acquires word alignment from control tokens (requesting bitslips
// from the deserializer) and decodes tokens / video symbols into de, ctl and pixel data.
module tmds_channel_decoder #(
    parameter int unsigned CTRL_RUN      = 8,
    parameter int unsigned SEARCH_WINDOW = 4096,
    parameter int unsigned SLIP_WAIT     = 16
) (
    input  logic       pixel_clk,
    input  logic       rst,
    input  logic [9:0] tmds_symbol,
    output logic       bitslip,
    output logic       aligned,
    output logic       de,
    output logic [1:0] ctl,
    output logic [7:0] pixel_data,
    output logic       symbol_err
);

    localparam int unsigned RW = $clog2(CTRL_RUN) + 1;
    localparam int unsigned WW = $clog2(SEARCH_WINDOW) + 1;
    localparam int unsigned SW = $clog2(SLIP_WAIT) + 1;

    typedef enum logic [1:0] {
        ST_SEARCH,
        ST_SLIP,
        ST_SETTLE,
        ST_LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [9:0]    s1_q;
    logic [RW-1:0] run_q, run_d, run_inc;
    logic [WW-1:0] win_q, win_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          de_q, de_d;
    logic [1:0]    ctl_q, ctl_d;
    logic [7:0]    pix_q, pix_d;
    logic          err_q, err_d;

    logic          is_tok;
    logic [1:0]    tok_ctl;
    logic [7:0]    q_lo;
    logic [7:0]    dec;
    logic [3:0]    ones;
    logic          legal;

    // Symbol classification and video decode on the registered symbol
    always_comb begin
        is_tok  = 1'b1;
        tok_ctl = 2'b00;
        case (s1_q)
            10'b1101010100: tok_ctl = 2'b00;
            10'b0010101011: tok_ctl = 2'b01;
            10'b0101010100: tok_ctl = 2'b10;
            10'b1010101011: tok_ctl = 2'b11;
            default:        is_tok  = 1'b0;
        endcase

        q_lo   = s1_q[9] ? ~s1_q[7:0] : s1_q[7:0];
        dec    = '0;
        dec[0] = q_lo[0];
        for (int unsigned i = 1; i < 8; i++) begin
            dec[i] = s1_q[8] ? (q_lo[i] ^ q_lo[i-1]) : ~(q_lo[i] ^ q_lo[i-1]);
        end

        ones = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            ones = ones + 4'(q_lo[i]);
        end
        legal = !is_tok && (ones >= 4'd2) && (ones <= 4'd8);
    end

    always_comb begin
        state_d  = state_q;
        run_d    = run_q;
        win_d    = win_q;
        settle_d = settle_q;
        run_inc  = (run_q == RW'(CTRL_RUN)) ? run_q : run_q + 1'b1;

        case (state_q)
            ST_SEARCH: begin
                run_d = is_tok ? run_inc : '0;
                win_d = win_q + 1'b1;
                // Lock takes priority over an expiring window on the same cycle
                if (is_tok && run_inc == RW'(CTRL_RUN)) begin
                    state_d = ST_LOCKED;
                    run_d   = '0;
                    win_d   = '0;
                end else if (win_q == WW'(SEARCH_WINDOW - 1)) begin
                    state_d = ST_SLIP;
                    run_d   = '0;
                    win_d   = '0;
                end
            end
            ST_SLIP: begin
                state_d  = ST_SETTLE;
                run_d    = '0;
                win_d    = '0;
                settle_d = '0;
            end
            ST_SETTLE: begin
                run_d = '0;
                win_d = '0;
                if (settle_q == SW'(SLIP_WAIT - 1)) begin
                    state_d  = ST_SEARCH;
                    settle_d = '0;
                end else begin
                    settle_d = settle_q + 1'b1;
                end
            end
            ST_LOCKED: begin
                run_d = '0;
                if (is_tok) begin
                    win_d = '0;
                end else if (win_q == WW'(SEARCH_WINDOW - 1)) begin
                    state_d = ST_SEARCH;
                    win_d   = '0;
                end else begin
                    win_d = win_q + 1'b1;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    // Outputs follow the state being entered, so they change together with aligned
    always_comb begin
        de_d  = 1'b0;
        ctl_d = ctl_q;
        pix_d = pix_q;
        err_d = 1'b0;
        if (state_d == ST_LOCKED) begin
            if (is_tok) begin
                ctl_d = tok_ctl;
            end else begin
                de_d  = 1'b1;
                pix_d = dec;
                err_d = !legal;
            end
        end else begin
            ctl_d = '0;
            pix_d = '0;
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            state_q  <= ST_SEARCH;
            s1_q     <= '0;
            run_q    <= '0;
            win_q    <= '0;
            settle_q <= '0;
            de_q     <= 1'b0;
            ctl_q    <= '0;
            pix_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            s1_q     <= tmds_symbol;
            run_q    <= run_d;
            win_q    <= win_d;
            settle_q <= settle_d;
            de_q     <= de_d;
            ctl_q    <= ctl_d;
            pix_q    <= pix_d;
            err_q    <= err_d;
        end
    end

    assign bitslip    = (state_q == ST_SLIP);
    assign aligned    = (state_q == ST_LOCKED);
    assign de         = de_q;
    assign ctl        = ctl_q;
    assign pixel_data = pix_q;
    assign symbol_err = err_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Self-checking bench for tmds_channel_decoder: randomized symbol streams checked against
// a behavioural model, plus alignment / bitslip / reset timing scenarios.
module tb_tmds_channel_decoder;

    localparam int unsigned CR  = 8;
    localparam int unsigned SW  = 256;
    localparam int unsigned SLW = 16;

    localparam logic [9:0] TOK0 = 10'b1101010100;
    localparam logic [9:0] TOK1 = 10'b0010101011;
    localparam logic [9:0] TOK2 = 10'b0101010100;
    localparam logic [9:0] TOK3 = 10'b1010101011;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] sym;
    logic       bitslip, aligned, de, symbol_err;
    logic [1:0] ctl;
    logic [7:0] pixel_data;

    int checks   = 0;
    int failures = 0;

    logic [1:0] m_ctl;
    logic [7:0] m_pix;

    tmds_channel_decoder #(
        .CTRL_RUN      (CR),
        .SEARCH_WINDOW (SW),
        .SLIP_WAIT     (SLW)
    ) dut (
        .pixel_clk  (clk),
        .rst        (rst),
        .tmds_symbol(sym),
        .bitslip    (bitslip),
        .aligned    (aligned),
        .de         (de),
        .ctl        (ctl),
        .pixel_data (pixel_data),
        .symbol_err (symbol_err)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic bit tok_of(input logic [9:0] s, output logic [1:0] c);
        c = 2'b00;
        if (s == TOK0) begin c = 2'b00; return 1'b1; end
        if (s == TOK1) begin c = 2'b01; return 1'b1; end
        if (s == TOK2) begin c = 2'b10; return 1'b1; end
        if (s == TOK3) begin c = 2'b11; return 1'b1; end
        return 1'b0;
    endfunction

    function automatic int unsigned lo_byte(input logic [9:0] s);
        return s[9] ? (255 - 32'(s[7:0])) : 32'(s[7:0]);
    endfunction

    function automatic logic [7:0] ref_decode(input logic [9:0] s);
        int unsigned b, r, cur, prv;
        b = lo_byte(s);
        r = b % 2;
        for (int unsigned i = 1; i < 8; i++) begin
            cur = (b >> i) % 2;
            prv = (b >> (i - 1)) % 2;
            if ((cur != prv) == s[8]) r += (1 << i);
        end
        return 8'(r);
    endfunction

    function automatic bit ref_legal(input logic [9:0] s);
        logic [1:0]  c;
        int unsigned b, n;
        if (tok_of(s, c)) return 1'b0;
        b = lo_byte(s);
        n = 0;
        for (int unsigned i = 0; i < 8; i++) n += (b >> i) % 2;
        return (n >= 2) && (n <= 8);
    endfunction

    // Transmit-side TMDS encoding (transition minimisation, optional inversion)
    function automatic logic [9:0] tmds_encode(input logic [7:0] d, input bit inv);
        logic [8:0]  qm;
        int unsigned n1;
        bit          xn;
        n1    = $countones(d);
        xn    = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
        qm    = '0;
        qm[0] = d[0];
        for (int unsigned i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
        qm[8] = !xn;
        return inv ? {1'b1, qm[8], ~qm[7:0]} : {1'b0, qm};
    endfunction

    // Word seen by a deserializer whose boundary is k bits late in a TOK0 stream
    function automatic logic [9:0] rot_word(input int unsigned k);
        logic [9:0] w;
        logic [9:0] t;
        t = TOK0;
        for (int unsigned i = 0; i < 10; i++) w[i] = t[(i + k) % 10];
        return w;
    endfunction

    function automatic logic [9:0] rand_tok();
        case ($urandom_range(3))
            0:       return TOK0;
            1:       return TOK1;
            2:       return TOK2;
            default: return TOK3;
        endcase
    endfunction

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        m_ctl = 2'b00;
        m_pix = 8'h00;
    endtask

    task automatic model_step(input logic [9:0] p, output logic e_de, output logic e_err);
        logic [1:0] c;
        if (tok_of(p, c)) begin
            e_de  = 1'b0;
            e_err = 1'b0;
            m_ctl = c;
        end else begin
            e_de  = 1'b1;
            e_err = !ref_legal(p);
            m_pix = ref_decode(p);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sym = 10'($urandom);
        repeat (3) cyc();
        checks++;
        if ({bitslip, aligned, de, ctl, pixel_data, symbol_err} !== 14'd0) begin
            failures++;
            $display("FAIL reset_outputs got bs=%b al=%b de=%b ctl=%b pix=%h err=%b exp all 0",
                     bitslip, aligned, de, ctl, pixel_data, symbol_err);
        end
        rst   = 1'b0;
        m_ctl = 2'b00;
        m_pix = 8'h00;
    endtask

    task automatic test_lock();
        sym = TOK0;
        for (int unsigned n = 1; n <= CR + 1; n++) begin
            cyc();
            checks++;
            if (aligned !== (n == CR + 1) || bitslip !== 1'b0) begin
                failures++;
                $display("FAIL lock_timing[%0d] got al=%b bs=%b exp al=%b bs=0", n, aligned, bitslip, (n == CR + 1));
            end
        end
        checks++;
        if (de !== 1'b0 || ctl !== 2'b00) begin
            failures++;
            $display("FAIL lock_outputs got de=%b ctl=%b exp de=0 ctl=00", de, ctl);
        end
    endtask

    task automatic test_video_directed();
        logic [9:0] seq[$];
        logic [9:0] prev;
        logic       e_de, e_err;
        seq  = '{10'b0100000000, 10'b1011111111, 10'b1000000001, TOK0, TOK0};
        prev = sym;
        foreach (seq[i]) begin
            sym = seq[i];
            cyc();
            model_step(prev, e_de, e_err);
            checks++;
            if (aligned !== 1'b1 || de !== e_de || ctl !== m_ctl || pixel_data !== m_pix || symbol_err !== e_err) begin
                failures++;
                $display("FAIL video_directed[%0d] got al=%b de=%b ctl=%b pix=%h err=%b exp al=1 de=%b ctl=%b pix=%h err=%b",
                         i, aligned, de, ctl, pixel_data, symbol_err, e_de, m_ctl, m_pix, e_err);
            end
            prev = seq[i];
        end
    endtask

    task automatic test_ctl_tokens();
        logic [9:0] seq[$];
        logic [9:0] prev;
        logic       e_de, e_err;
        seq  = '{TOK1, TOK2, TOK3, tmds_encode(8'h5A, 1'b0), tmds_encode(8'hC3, 1'b1), TOK0, TOK0};
        prev = sym;
        foreach (seq[i]) begin
            sym = seq[i];
            cyc();
            model_step(prev, e_de, e_err);
            checks++;
            if (aligned !== 1'b1 || de !== e_de || ctl !== m_ctl || pixel_data !== m_pix || symbol_err !== e_err) begin
                failures++;
                $display("FAIL ctl_tokens[%0d] got al=%b de=%b ctl=%b pix=%h err=%b exp al=1 de=%b ctl=%b pix=%h err=%b",
                         i, aligned, de, ctl, pixel_data, symbol_err, e_de, m_ctl, m_pix, e_err);
            end
            prev = seq[i];
        end
    endtask

    task automatic test_symbol_err();
        logic [9:0] seq[$];
        logic [9:0] prev;
        logic       e_de, e_err;
        seq  = '{10'b0110011001, 10'b0000000000, 10'b1010011001, TOK2, 10'b0000000000, TOK0, TOK0};
        prev = sym;
        foreach (seq[i]) begin
            sym = seq[i];
            cyc();
            model_step(prev, e_de, e_err);
            checks++;
            if (aligned !== 1'b1 || de !== e_de || ctl !== m_ctl || pixel_data !== m_pix || symbol_err !== e_err) begin
                failures++;
                $display("FAIL symbol_err[%0d] got al=%b de=%b ctl=%b pix=%h err=%b exp al=1 de=%b ctl=%b pix=%h err=%b",
                         i, aligned, de, ctl, pixel_data, symbol_err, e_de, m_ctl, m_pix, e_err);
            end
            prev = seq[i];
        end
    endtask

    task automatic test_random_raw();
        logic [9:0] prev, s;
        logic       e_de, e_err;
        prev = sym;
        for (int unsigned i = 0; i < 300; i++) begin
            s   = (i % 16 == 15 || i >= 298) ? rand_tok() : 10'($urandom);
            sym = s;
            cyc();
            model_step(prev, e_de, e_err);
            checks++;
            if (aligned !== 1'b1 || de !== e_de || ctl !== m_ctl || pixel_data !== m_pix || symbol_err !== e_err) begin
                failures++;
                $display("FAIL random_raw[%0d] sym=%b got al=%b de=%b ctl=%b pix=%h err=%b exp al=1 de=%b ctl=%b pix=%h err=%b",
                         i, prev, aligned, de, ctl, pixel_data, symbol_err, e_de, m_ctl, m_pix, e_err);
            end
            prev = s;
        end
    endtask

    // Encoded bytes must come back unchanged through the decoder
    task automatic test_random_encoded();
        logic [9:0] prev, s;
        logic [7:0] d;
        logic [1:0] c;
        logic       e_de, e_err;
        prev = sym;
        for (int unsigned i = 0; i < 300; i++) begin
            d = 8'($urandom);
            s = tmds_encode(d, 1'($urandom));
            if (i % 20 == 19 || i >= 298 || tok_of(s, c)) s = rand_tok();
            sym = s;
            cyc();
            model_step(prev, e_de, e_err);
            checks++;
            if (aligned !== 1'b1 || de !== e_de || ctl !== m_ctl || pixel_data !== m_pix) begin
                failures++;
                $display("FAIL random_encoded[%0d] sym=%b got al=%b de=%b ctl=%b pix=%h exp al=1 de=%b ctl=%b pix=%h",
                         i, prev, aligned, de, ctl, pixel_data, e_de, m_ctl, m_pix);
            end
            prev = s;
        end
    endtask

    task automatic test_lock_loss();
        logic [9:0] s;
        logic [1:0] c;
        bit         exp_al;
        for (int unsigned k = 1; k <= SW + 1; k++) begin
            if (k <= SW) begin
                s = tmds_encode(8'($urandom), 1'($urandom));
                if (tok_of(s, c)) s = tmds_encode(8'h00, 1'b0);
            end else begin
                s = TOK0;
            end
            sym = s;
            cyc();
            exp_al = (k <= SW);
            checks++;
            if (aligned !== exp_al || bitslip !== 1'b0) begin
                failures++;
                $display("FAIL lock_loss[%0d] got al=%b bs=%b exp al=%b bs=0", k, aligned, bitslip, exp_al);
            end
        end
        checks++;
        if (de !== 1'b0 || pixel_data !== 8'h00 || ctl !== 2'b00) begin
            failures++;
            $display("FAIL lock_loss_outputs got de=%b pix=%h ctl=%b exp de=0 pix=00 ctl=00", de, pixel_data, ctl);
        end
        for (int unsigned j = 1; j <= CR; j++) begin
            sym = TOK0;
            cyc();
            checks++;
            if (aligned !== (j == CR) || bitslip !== 1'b0) begin
                failures++;
                $display("FAIL relock[%0d] got al=%b bs=%b exp al=%b bs=0", j, aligned, bitslip, (j == CR));
            end
        end
        m_ctl = 2'b00;
        m_pix = 8'h00;
    endtask

    task automatic test_bitslip();
        int unsigned off, pulses, n;
        int          budget;
        bit          quiet;
        off    = 7;
        sym    = rot_word(off);
        do_reset();
        pulses = 0;
        n      = 0;
        budget = 4 * (SW + SLW + 4) + CR + 20;
        while (aligned !== 1'b1 && budget > 0) begin
            sym = rot_word(off);
            cyc();
            n++;
            budget--;
            if (bitslip === 1'b1) begin
                pulses++;
                if (pulses == 1) begin
                    checks++;
                    if (n != SW) begin
                        failures++;
                        $display("FAIL first_slip_delay got %0d cycles exp %0d", n, SW);
                    end
                end
                off   = (off + 1) % 10;
                quiet = 1'b1;
                for (int unsigned k = 0; k <= SLW; k++) begin
                    sym = rot_word(off);
                    cyc();
                    budget--;
                    if (bitslip !== 1'b0) quiet = 1'b0;
                end
                checks++;
                if (!quiet) begin
                    failures++;
                    $display("FAIL slip_quiet[%0d] got extra bitslip exp none for %0d cycles", pulses, SLW + 1);
                end
            end
        end
        checks++;
        if (aligned !== 1'b1 || pulses != 3) begin
            failures++;
            $display("FAIL slip_align got al=%b pulses=%0d exp al=1 pulses=3", aligned, pulses);
        end
        m_ctl = 2'b00;
        m_pix = 8'h00;
    endtask

    task automatic test_reset_mid();
        int unsigned n;
        sym = rot_word(3);
        do_reset();
        n = 0;
        while (bitslip !== 1'b1 && n < SW + 8) begin cyc(); n++; end
        checks++;
        if (n != SW) begin
            failures++;
            $display("FAIL pulse_delay got %0d exp %0d", n, SW);
        end
        rst = 1'b1;
        cyc();
        checks++;
        if ({bitslip, aligned, de, ctl, pixel_data, symbol_err} !== 14'd0) begin
            failures++;
            $display("FAIL rst_in_pulse got bs=%b al=%b de=%b ctl=%b pix=%h err=%b exp all 0",
                     bitslip, aligned, de, ctl, pixel_data, symbol_err);
        end
        rst = 1'b0;
        n   = 0;
        while (bitslip !== 1'b1 && n < SW + 8) begin cyc(); n++; end
        checks++;
        if (n != SW) begin
            failures++;
            $display("FAIL pulse_after_rst got %0d exp %0d", n, SW);
        end
        repeat (5) cyc();
        rst = 1'b1;
        cyc();
        checks++;
        if ({bitslip, aligned, de, ctl, pixel_data, symbol_err} !== 14'd0) begin
            failures++;
            $display("FAIL rst_in_settle got bs=%b al=%b de=%b ctl=%b pix=%h err=%b exp all 0",
                     bitslip, aligned, de, ctl, pixel_data, symbol_err);
        end
        rst = 1'b0;
        n   = 0;
        while (bitslip !== 1'b1 && n < SW + 8) begin cyc(); n++; end
        checks++;
        if (n != SW) begin
            failures++;
            $display("FAIL search_after_settle_rst got %0d exp %0d", n, SW);
        end
    endtask

    initial begin
        rst   = 1'b1;
        sym   = '0;
        m_ctl = 2'b00;
        m_pix = 8'h00;
        test_reset();
        test_lock();
        test_video_directed();
        test_ctl_tokens();
        test_symbol_err();
        test_random_raw();
        test_random_encoded();
        test_lock_loss();
        test_bitslip();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
